fwrisc_trap_ctrl: RTL and testbench

//  Trap/interrupt sequencer for the fwrisc core. Sits between execute and fwrisc_regfile:
//  - consumes the mtvec/mie/meie state the regfile exports;
//  - drives the regfile's trap/tret/irq inputs;
//  - writes MEPC/MCAUSE through a CSR write port that the core muxes onto the regfile rd port;
//  - issues the PC redirect for exceptions, interrupts and MRET.

---
 rtl/fwrisc_trap_pkg.sv | 44 ++++
 rtl/fwrisc_sync.sv | 34 +++
 rtl/fwrisc_trap_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fwrisc_trap_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_trap_pkg.sv
// fwrisc_trap_pkg
//   Shared types and constants for the fwrisc trap/interrupt sequencer.
//   Contents:
//     trap_state_e  : sequencer states (IDLE, WR_EPC, WR_CAUSE, REDIR, RET)
//     CAUSE_*       : 4-bit machine cause codes used by the sequencer
//     CSR_MEPC/CSR_MCAUSE : 6-bit regfile CSR indices driven on csr_waddr
//     trapVector()  : computes the trap entry address from a latched mtvec
package fwrisc_trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_EPC   = 3'd1,
        WR_CAUSE = 3'd2,
        REDIR    = 3'd3,
        RET      = 3'd4
    } trap_state_e;

    // Machine cause codes (low four bits of MCAUSE)
    localparam logic [3:0] CAUSE_MEI            = 4'd11;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;

    // Regfile CSR indices for the CSR write port
    localparam logic [5:0] CSR_MEPC   = 6'h29;
    localparam logic [5:0] CSR_MCAUSE = 6'h2A;

    // Direct mode jumps to the aligned base; vectored mode (mtvec[1:0]==01)
    // offsets interrupts by 4*cause. Exceptions always use the base.
    function automatic logic [31:0] trapVector(
        input logic [31:0] mtvecVal,
        input logic [3:0]  code,
        input logic        isInt,
        input logic        vectoredEn
    );
        logic [31:0] base;
        base = {mtvecVal[31:2], 2'b00};
        if (vectoredEn && (mtvecVal[1:0] == 2'b01) && isInt) begin
            return base + {26'b0, code, 2'b00};
        end
        return base;
    endfunction

endpackage

// File: rtl/fwrisc_sync.sv
// fwrisc_sync
//   STAGES-deep flop chain used to bring an asynchronous level into the
//   clock domain. Synchronous active-high reset clears every stage.
//   Ports:
//     clock : core clock
//     reset : synchronous, active-high
//     i_d   : asynchronous input level
//     o_q   : synchronised level, i_d delayed by STAGES clocks
module fwrisc_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the input level through the chain one stage per clock
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/fwrisc_trap_ctrl.sv
// fwrisc_trap_ctrl
//   Trap/interrupt sequencer between execute and fwrisc_regfile. On an
//   exception or interrupt it writes MEPC then MCAUSE through the CSR write
//   port and redirects fetch to the trap vector; on MRET it redirects to MEPC.
//   Ports:
//     clock, reset        : core clock, synchronous active-high reset
//     irq_i               : asynchronous external interrupt level
//     instr_complete      : instruction boundary (retiring this cycle)
//     next_pc             : PC after the retiring instruction (interrupt EPC)
//     exc_req/exc_cause/exc_pc : synchronous exception request pulse + data
//     mret_req            : MRET executing (pulse)
//     mepc                : current MEPC from the CSR read path
//     mtvec, mie, meie    : trap state exported by the regfile
//     irq                 : synchronised irq level (MIP.MEIP)
//     trap, tret          : one-cycle pulses to the regfile
//     csr_wen/csr_waddr/csr_wdata : MEPC/MCAUSE write port
//     hold                : stall the core while the sequence runs
//     pc_redirect/pc_target : fetch redirect pulse and address
module fwrisc_trap_ctrl
    import fwrisc_trap_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2,
    parameter bit ENABLE_VECTORED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        irq_i,
    input  logic        instr_complete,
    input  logic [31:0] next_pc,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    input  logic [31:0] mtvec,
    input  logic        mie,
    input  logic        meie,
    output logic        irq,
    output logic        trap,
    output logic        tret,
    output logic        csr_wen,
    output logic [5:0]  csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        hold,
    output logic        pc_redirect,
    output logic [31:0] pc_target
);

    trap_state_e r_state;
    trap_state_e w_nextState;

    logic        r_int;
    logic [3:0]  r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_mtvec;

    logic        w_intTake;
    logic        w_trapTake;
    logic [31:0] w_vector;
    logic        w_unused_mepc0;

    fwrisc_sync #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irqSync (
        .clock (clock),
        .reset (reset),
        .i_d   (irq_i),
        .o_q   (irq)
    );

    // Interrupts are only taken at an instruction boundary and lose to any
    // exception or MRET presented in the same cycle.
    assign w_intTake  = irq && mie && meie && instr_complete && !exc_req && !mret_req;
    assign w_trapTake = exc_req || w_intTake;

    assign w_vector       = trapVector(r_mtvec, r_cause, r_int, ENABLE_VECTORED);
    assign w_unused_mepc0 = mepc[0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture everything the trap sequence needs at the moment it is taken,
    // so later changes to mtvec/PC inputs cannot disturb a sequence in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_int   <= 1'b0;
            r_cause <= 4'd0;
            r_epc   <= 32'd0;
            r_mtvec <= 32'd0;
        end else if (r_state == IDLE && w_trapTake) begin
            r_int   <= !exc_req;
            r_cause <= exc_req ? exc_cause : CAUSE_MEI;
            r_epc   <= exc_req ? exc_pc : next_pc;
            r_mtvec <= mtvec;
        end
    end

    // Next-state: requests are only looked at in IDLE, everything else runs
    // straight through.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (exc_req) begin
                    w_nextState = WR_EPC;
                end else if (mret_req) begin
                    w_nextState = RET;
                end else if (w_intTake) begin
                    w_nextState = WR_EPC;
                end
            end
            WR_EPC:   w_nextState = WR_CAUSE;
            WR_CAUSE: w_nextState = REDIR;
            REDIR:    w_nextState = IDLE;
            RET:      w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Outputs decode from state. Reset forces them low at once so a sequence
    // cut short by reset never completes its pending CSR write.
    always_comb begin
        trap        = 1'b0;
        tret        = 1'b0;
        csr_wen     = 1'b0;
        csr_waddr   = 6'd0;
        csr_wdata   = 32'd0;
        hold        = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        if (!reset) begin
            case (r_state)
                WR_EPC: begin
                    trap      = 1'b1;
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = r_epc;
                    hold      = 1'b1;
                end
                WR_CAUSE: begin
                    csr_wen   = 1'b1;
                    csr_waddr = CSR_MCAUSE;
                    csr_wdata = {r_int, 27'b0, r_cause};
                    hold      = 1'b1;
                end
                REDIR: begin
                    pc_redirect = 1'b1;
                    pc_target   = w_vector;
                    hold        = 1'b1;
                end
                RET: begin
                    tret        = 1'b1;
                    pc_redirect = 1'b1;
                    pc_target   = {mepc[31:1], 1'b0};
                    hold        = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_trap_ctrl.sv
// tb_fwrisc_trap_ctrl
//   Self-checking bench for fwrisc_trap_ctrl. Two instances share inputs:
//   dut0 (2 sync stages, vectored enabled) and dut1 (3 sync stages, direct
//   mode only). A table of trap scenarios is run in a loop, followed by
//   hand-written sequences for MRET, masked irq, dropped requests and reset.
module tb_fwrisc_trap_ctrl;
    import fwrisc_trap_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        irq_i = 1'b0;
    logic        instr_complete = 1'b0;
    logic [31:0] next_pc = 32'd0;
    logic        exc_req = 1'b0;
    logic [3:0]  exc_cause = 4'd0;
    logic [31:0] exc_pc = 32'd0;
    logic        mret_req = 1'b0;
    logic [31:0] mepc = 32'd0;
    logic [31:0] mtvec = 32'd0;
    logic        mie = 1'b0;
    logic        meie = 1'b0;

    logic        irq0, trap0, tret0, csrWen0, hold0, redirect0;
    logic [5:0]  csrWaddr0;
    logic [31:0] csrWdata0, target0;
    logic        irq1, trap1, tret1, csrWen1, hold1, redirect1;
    logic [5:0]  csrWaddr1;
    logic [31:0] csrWdata1, target1;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic        isExc;
        logic        irqLevel;
        logic [31:0] mtvecVal;
        logic [31:0] nextPc;
        logic [3:0]  excCause;
        logic [31:0] excPc;
        logic [31:0] expMepc;
        logic [31:0] expCause;
        logic [31:0] expTarget0;
        logic [31:0] expTarget1;
    } vec_t;

    vec_t vecs[6];

    fwrisc_trap_ctrl #(
        .IRQ_SYNC_STAGES (2),
        .ENABLE_VECTORED (1'b1)
    ) dut0 (
        .clock          (clock),
        .reset          (reset),
        .irq_i          (irq_i),
        .instr_complete (instr_complete),
        .next_pc        (next_pc),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_req       (mret_req),
        .mepc           (mepc),
        .mtvec          (mtvec),
        .mie            (mie),
        .meie           (meie),
        .irq            (irq0),
        .trap           (trap0),
        .tret           (tret0),
        .csr_wen        (csrWen0),
        .csr_waddr      (csrWaddr0),
        .csr_wdata      (csrWdata0),
        .hold           (hold0),
        .pc_redirect    (redirect0),
        .pc_target      (target0)
    );

    fwrisc_trap_ctrl #(
        .IRQ_SYNC_STAGES (3),
        .ENABLE_VECTORED (1'b0)
    ) dut1 (
        .clock          (clock),
        .reset          (reset),
        .irq_i          (irq_i),
        .instr_complete (instr_complete),
        .next_pc        (next_pc),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_req       (mret_req),
        .mepc           (mepc),
        .mtvec          (mtvec),
        .mie            (mie),
        .meie           (meie),
        .irq            (irq1),
        .trap           (trap1),
        .tret           (tret1),
        .csr_wen        (csrWen1),
        .csr_waddr      (csrWaddr1),
        .csr_wdata      (csrWdata1),
        .hold           (hold1),
        .pc_redirect    (redirect1),
        .pc_target      (target1)
    );

    // Free-running 10-unit clock
    always #5 clock = ~clock;

    // Safety net so the run always ends even if something stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish (actual running, required finished)");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mkVec(
        input logic isExc, input logic irqLevel, input logic [31:0] mtvecVal,
        input logic [31:0] nextPc, input logic [3:0] excCause, input logic [31:0] excPc,
        input logic [31:0] expMepc, input logic [31:0] expCause,
        input logic [31:0] expTarget0, input logic [31:0] expTarget1
    );
        vec_t v;
        v.isExc = isExc;           v.irqLevel = irqLevel;
        v.mtvecVal = mtvecVal;     v.nextPc = nextPc;
        v.excCause = excCause;     v.excPc = excPc;
        v.expMepc = expMepc;       v.expCause = expCause;
        v.expTarget0 = expTarget0; v.expTarget1 = expTarget1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        instr_complete = 1'b0;
        exc_req = 1'b0;
        mret_req = 1'b0;
        mie = 1'b0;
        meie = 1'b0;
    endtask

    // One table scenario: settle irq through the synchronisers with the
    // enables off, present the request for one cycle, then scramble the
    // inputs and follow the three-cycle write/redirect sequence.
    task automatic applyStimulus(input int idx, input vec_t v);
        idleInputs();
        irq_i = v.irqLevel;
        mtvec = v.mtvecVal;
        repeat (4) stepCycle();
        checkOutput($sformatf("v%0d irq synced", idx), {31'b0, irq0}, {31'b0, v.irqLevel});

        mie = 1'b1;
        meie = 1'b1;
        instr_complete = 1'b1;
        next_pc = v.nextPc;
        exc_req = v.isExc;
        exc_cause = v.excCause;
        exc_pc = v.excPc;
        stepCycle();

        idleInputs();
        mtvec = 32'hDEAD_BEE1;
        next_pc = 32'h1111_1111;
        exc_pc = 32'h2222_2222;
        exc_cause = 4'hF;
        checkOutput($sformatf("v%0d epc trap", idx), {31'b0, trap0}, 32'd1);
        checkOutput($sformatf("v%0d epc wen", idx), {31'b0, csrWen0}, 32'd1);
        checkOutput($sformatf("v%0d epc waddr", idx), {26'b0, csrWaddr0}, {26'b0, CSR_MEPC});
        checkOutput($sformatf("v%0d epc wdata", idx), csrWdata0, v.expMepc);
        checkOutput($sformatf("v%0d epc wdata dut1", idx), csrWdata1, v.expMepc);
        checkOutput($sformatf("v%0d epc hold", idx), {31'b0, hold0}, 32'd1);
        checkOutput($sformatf("v%0d epc redirect", idx), {31'b0, redirect0}, 32'd0);

        stepCycle();
        checkOutput($sformatf("v%0d cause trap", idx), {31'b0, trap0}, 32'd0);
        checkOutput($sformatf("v%0d cause waddr", idx), {26'b0, csrWaddr0}, {26'b0, CSR_MCAUSE});
        checkOutput($sformatf("v%0d cause wdata", idx), csrWdata0, v.expCause);
        checkOutput($sformatf("v%0d cause hold", idx), {31'b0, hold0}, 32'd1);

        stepCycle();
        checkOutput($sformatf("v%0d redir pulse", idx), {31'b0, redirect0}, 32'd1);
        checkOutput($sformatf("v%0d redir target", idx), target0, v.expTarget0);
        checkOutput($sformatf("v%0d redir target dut1", idx), target1, v.expTarget1);
        checkOutput($sformatf("v%0d redir wen", idx), {31'b0, csrWen0}, 32'd0);
        checkOutput($sformatf("v%0d redir hold", idx), {31'b0, hold0}, 32'd1);

        stepCycle();
        checkOutput($sformatf("v%0d done hold", idx), {31'b0, hold0}, 32'd0);
        checkOutput($sformatf("v%0d done redirect", idx), {31'b0, redirect0}, 32'd0);
    endtask

    // Main test sequence
    initial begin
        vecs[0] = mkVec(1'b0, 1'b1, 32'h0000_0100, 32'h0000_2004, 4'd0, 32'h0,
                        32'h0000_2004, 32'h8000_000B, 32'h0000_0100, 32'h0000_0100);
        vecs[1] = mkVec(1'b0, 1'b1, 32'h0000_0101, 32'h0000_3000, 4'd0, 32'h0,
                        32'h0000_3000, 32'h8000_000B, 32'h0000_012C, 32'h0000_0100);
        vecs[2] = mkVec(1'b1, 1'b1, 32'h0000_0101, 32'h0000_0044, CAUSE_ECALL_M, 32'h0000_0040,
                        32'h0000_0040, 32'h0000_000B, 32'h0000_0100, 32'h0000_0100);
        vecs[3] = mkVec(1'b1, 1'b0, 32'h0000_0203, 32'h0000_1238, CAUSE_BREAKPOINT, 32'h0000_1234,
                        32'h0000_1234, 32'h0000_0003, 32'h0000_0200, 32'h0000_0200);
        vecs[4] = mkVec(1'b1, 1'b0, 32'hFFFF_FF01, 32'h0, CAUSE_INSTR_MISALIGN, 32'h8000_0002,
                        32'h8000_0002, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00);
        vecs[5] = mkVec(1'b0, 1'b1, 32'h8000_0001, 32'hABCD_0000, 4'd0, 32'h0,
                        32'hABCD_0000, 32'h8000_000B, 32'h8000_002C, 32'h8000_0000);

        // Reset state
        reset = 1'b1;
        irq_i = 1'b1;
        repeat (3) stepCycle();
        checkOutput("reset irq", {31'b0, irq0}, 32'd0);
        checkOutput("reset trap", {31'b0, trap0}, 32'd0);
        checkOutput("reset tret", {31'b0, tret0}, 32'd0);
        checkOutput("reset wen", {31'b0, csrWen0}, 32'd0);
        checkOutput("reset hold", {31'b0, hold0}, 32'd0);
        checkOutput("reset redirect", {31'b0, redirect0}, 32'd0);
        checkOutput("reset target", target0, 32'd0);
        checkOutput("reset irq dut1", {31'b0, irq1}, 32'd0);
        reset = 1'b0;
        irq_i = 1'b0;
        stepCycle();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // MRET with a pending enabled interrupt at a boundary: RET wins
        idleInputs();
        irq_i = 1'b1;
        repeat (4) stepCycle();
        mepc = 32'h0000_2005;
        mie = 1'b1;
        meie = 1'b1;
        instr_complete = 1'b1;
        mret_req = 1'b1;
        stepCycle();
        idleInputs();
        checkOutput("mret tret", {31'b0, tret0}, 32'd1);
        checkOutput("mret trap", {31'b0, trap0}, 32'd0);
        checkOutput("mret redirect", {31'b0, redirect0}, 32'd1);
        checkOutput("mret target", target0, 32'h0000_2004);
        checkOutput("mret hold", {31'b0, hold0}, 32'd1);
        checkOutput("mret wen", {31'b0, csrWen0}, 32'd0);
        checkOutput("mret tret dut1", {31'b0, tret1}, 32'd1);
        stepCycle();
        checkOutput("mret end tret", {31'b0, tret0}, 32'd0);
        checkOutput("mret end hold", {31'b0, hold0}, 32'd0);
        checkOutput("mret end redirect", {31'b0, redirect0}, 32'd0);

        // Masked interrupt: synchroniser latency visible, no trap either way
        irq_i = 1'b0;
        repeat (4) stepCycle();
        checkOutput("mask irq low", {31'b0, irq0}, 32'd0);
        irq_i = 1'b1;
        mie = 1'b1;
        meie = 1'b0;
        instr_complete = 1'b1;
        stepCycle();
        checkOutput("mask irq after 1", {31'b0, irq0}, 32'd0);
        stepCycle();
        checkOutput("mask irq after 2", {31'b0, irq0}, 32'd1);
        checkOutput("mask irq1 after 2", {31'b0, irq1}, 32'd0);
        checkOutput("mask meie hold", {31'b0, hold0}, 32'd0);
        stepCycle();
        checkOutput("mask irq1 after 3", {31'b0, irq1}, 32'd1);
        checkOutput("mask meie trap", {31'b0, trap0}, 32'd0);
        mie = 1'b0;
        meie = 1'b1;
        repeat (2) stepCycle();
        checkOutput("mask mie hold", {31'b0, hold0}, 32'd0);
        checkOutput("mask mie trap", {31'b0, trap0}, 32'd0);
        idleInputs();
        irq_i = 1'b0;
        repeat (4) stepCycle();

        // Requests arriving mid-sequence are dropped
        mtvec = 32'h0000_0600;
        exc_req = 1'b1;
        exc_cause = CAUSE_BREAKPOINT;
        exc_pc = 32'h0000_0500;
        stepCycle();
        exc_cause = CAUSE_INSTR_MISALIGN;
        exc_pc = 32'h0000_0900;
        checkOutput("drop epc wdata", csrWdata0, 32'h0000_0500);
        stepCycle();
        exc_req = 1'b0;
        mret_req = 1'b1;
        checkOutput("drop cause wdata", csrWdata0, 32'h0000_0003);
        stepCycle();
        mret_req = 1'b0;
        checkOutput("drop redir target", target0, 32'h0000_0600);
        stepCycle();
        checkOutput("drop idle hold", {31'b0, hold0}, 32'd0);
        checkOutput("drop idle tret", {31'b0, tret0}, 32'd0);
        stepCycle();
        checkOutput("drop idle2 hold", {31'b0, hold0}, 32'd0);
        checkOutput("drop idle2 trap", {31'b0, trap0}, 32'd0);

        // Reset asserted while in WR_CAUSE aborts the sequence
        irq_i = 1'b1;
        mtvec = 32'h0000_0100;
        exc_req = 1'b1;
        exc_cause = CAUSE_ECALL_M;
        exc_pc = 32'h0000_0040;
        stepCycle();
        exc_req = 1'b0;
        stepCycle();
        checkOutput("rst precond waddr", {26'b0, csrWaddr0}, {26'b0, CSR_MCAUSE});
        reset = 1'b1;
        #1;
        checkOutput("rst no mcause wen", {31'b0, csrWen0}, 32'd0);
        stepCycle();
        checkOutput("rst wen", {31'b0, csrWen0}, 32'd0);
        checkOutput("rst waddr", {26'b0, csrWaddr0}, 32'd0);
        checkOutput("rst wdata", csrWdata0, 32'd0);
        checkOutput("rst hold", {31'b0, hold0}, 32'd0);
        checkOutput("rst redirect", {31'b0, redirect0}, 32'd0);
        checkOutput("rst target", target0, 32'd0);
        checkOutput("rst irq", {31'b0, irq0}, 32'd0);
        reset = 1'b0;
        stepCycle();
        checkOutput("rst after wen", {31'b0, csrWen0}, 32'd0);
        checkOutput("rst after redirect", {31'b0, redirect0}, 32'd0);
        stepCycle();
        checkOutput("rst after2 hold", {31'b0, hold0}, 32'd0);
        checkOutput("rst after2 redirect", {31'b0, redirect0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
